// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode path: opcode encodings, instruction
// field positions and the control-flow classifier used to stall issue.
package isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_BEQZ = 4'b1001;
  localparam logic [3:0] OP_BLTZ = 4'b1010;
  localparam logic [3:0] OP_BGTZ = 4'b1011;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_LI   = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  localparam int unsigned INST_W  = 16;
  localparam int unsigned OPCO_HI = 15;
  localparam int unsigned OPCO_LO = 12;
  localparam int unsigned RD_HI   = 11;
  localparam int unsigned RD_LO   = 8;
  localparam int unsigned RS_HI   = 7;
  localparam int unsigned RS_LO   = 4;
  localparam int unsigned RT_HI   = 3;
  localparam int unsigned RT_LO   = 0;
  localparam int unsigned JOFF_HI = 11;
  localparam int unsigned JOFF_LO = 10;

  // Branches and jumps redirect fetch, so issue must wait for resolution.
  function automatic logic is_ctrl_flow(input logic [3:0] opco);
    logic r;
    r = 1'b0;
    case (opco)
      OP_BEQZ, OP_BLTZ, OP_BGTZ, OP_JMP: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: registered write port, combinational read port.
// Contents are not reset; validity is tracked by the owner's count.
module inst_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the accepted entry at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Head entry read straight out of the array.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Instruction issue queue: circular FIFO between fetch and Control_Unit.
// Presents the head entry as decoded fields and stalls after any issued
// branch/jump until it is resolved or the pipeline is flushed.
module inst_issue_queue
  import isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     inst_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            inst_vld_in,
  output logic            full_out,
  output logic            empty_out,
  output logic [3:0]      opco_out,
  output logic [1:0]      jmp_off_out,
  output logic [3:0]      rd_out,
  output logic [3:0]      rs_out,
  output logic [3:0]      rt_out,
  output logic [PC_W-1:0] pc_out,
  output logic            inst_vld_out,
  input  logic            issue_in,
  input  logic            resolve_in,
  input  logic            flush_in
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = INST_W + PC_W;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [0:0]       r_state;

  logic             w_push;
  logic             w_pop;
  logic             w_vld;
  logic [ENT_W-1:0] w_head;
  logic [15:0]      w_inst;

  inst_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({pc_in, inst_in}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Handshake qualifiers; a flush cancels the storage write as well.
  always_comb begin
    full_out  = (r_count == CNT_FULL);
    empty_out = (r_count == '0);
    w_vld     = !empty_out && (r_state == ST_RUN);
    w_push    = inst_vld_in && !full_out && !flush_in;
    w_pop     = w_vld && issue_in;
    w_inst    = w_head[INST_W-1:0];
  end

  // Head fields are zeroed when not presented so Control_Unit sees a NOP.
  always_comb begin
    inst_vld_out = w_vld;
    opco_out     = '0;
    jmp_off_out  = '0;
    rd_out       = '0;
    rs_out       = '0;
    rt_out       = '0;
    pc_out       = '0;
    if (w_vld) begin
      opco_out    = w_inst[OPCO_HI:OPCO_LO];
      jmp_off_out = w_inst[JOFF_HI:JOFF_LO];
      rd_out      = w_inst[RD_HI:RD_LO];
      rs_out      = w_inst[RS_HI:RS_LO];
      rt_out      = w_inst[RT_HI:RT_LO];
      pc_out      = w_head[ENT_W-1:INST_W];
    end
  end

  // Pointers, occupancy and the issue-stall state machine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_RUN;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_RUN;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_state == ST_RUN) begin
        if (w_pop && is_ctrl_flow(w_inst[OPCO_HI:OPCO_LO])) r_state <= ST_WAIT;
      end else if (resolve_in) begin
        r_state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue (DEPTH=4, PC_W=16).
module tb_inst_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst_in;
  logic [15:0] pc_in;
  logic        inst_vld_in;
  logic        full_out;
  logic        empty_out;
  logic [3:0]  opco_out;
  logic [1:0]  jmp_off_out;
  logic [3:0]  rd_out;
  logic [3:0]  rs_out;
  logic [3:0]  rt_out;
  logic [15:0] pc_out;
  logic        inst_vld_out;
  logic        issue_in;
  logic        resolve_in;
  logic        flush_in;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  inst_issue_queue #(.DEPTH(4), .PC_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_in      (inst_in),
    .pc_in        (pc_in),
    .inst_vld_in  (inst_vld_in),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .opco_out     (opco_out),
    .jmp_off_out  (jmp_off_out),
    .rd_out       (rd_out),
    .rs_out       (rs_out),
    .rt_out       (rt_out),
    .pc_out       (pc_out),
    .inst_vld_out (inst_vld_out),
    .issue_in     (issue_in),
    .resolve_in   (resolve_in),
    .flush_in     (flush_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] pc);
    inst_in = w; pc_in = pc; inst_vld_in = 1'b1;
    step();
    inst_vld_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inst_in = 16'h1123; pc_in = 16'h0040; inst_vld_in = 1'b1;
    issue_in = 1'b0; resolve_in = 1'b0; flush_in = 1'b0;

    // Reset with a valid push held high
    step(); step();
    chk("rst_vld",   32'(inst_vld_out), 32'd0);
    chk("rst_empty", 32'(empty_out),    32'd1);
    chk("rst_full",  32'(full_out),     32'd0);
    chk("rst_opco",  32'(opco_out),     32'd0);
    rst_n = 1'b1; inst_vld_in = 1'b0;
    step();
    chk("rst_noenq", 32'(empty_out), 32'd1);

    // Fill and backpressure
    push(16'h1123, 16'h0100);
    chk("fill1_vld",  32'(inst_vld_out), 32'd1);
    chk("fill1_pc",   32'(pc_out),       32'h0100);
    push(16'h2456, 16'h0102);
    push(16'h3789, 16'h0104);
    chk("fill3_full", 32'(full_out), 32'd0);
    push(16'h4ABC, 16'h0106);
    chk("fill4_full", 32'(full_out), 32'd1);
    push(16'h5DEF, 16'h0108);
    chk("fill5_full", 32'(full_out), 32'd1);
    issue_in = 1'b1;
    chk("pop1", {opco_out, rd_out, rs_out, rt_out}, 32'h1123);
    step();
    chk("pop2", {opco_out, rd_out, rs_out, rt_out}, 32'h2456);
    chk("pop2_pc", 32'(pc_out), 32'h0102);
    step();
    chk("pop3", {opco_out, rd_out, rs_out, rt_out}, 32'h3789);
    step();
    chk("pop4", {opco_out, rd_out, rs_out, rt_out}, 32'h4ABC);
    step();
    issue_in = 1'b0;
    chk("drain_empty", 32'(empty_out),    32'd1);
    chk("drain_vld",   32'(inst_vld_out), 32'd0);
    chk("drain_opco",  32'(opco_out),     32'd0);

    // Simultaneous push and pop while full
    push(16'h1001, 16'h0200);
    push(16'h2002, 16'h0202);
    push(16'h3003, 16'h0204);
    push(16'h4004, 16'h0206);
    chk("sim_full", 32'(full_out), 32'd1);
    inst_in = 16'h5555; inst_vld_in = 1'b1; issue_in = 1'b1;
    step();
    inst_vld_in = 1'b0; issue_in = 1'b0;
    chk("sim_notfull", 32'(full_out), 32'd0);
    chk("sim_head",    32'(opco_out), 32'd2);
    issue_in = 1'b1;
    step();
    chk("sim_h3", 32'(opco_out), 32'd3);
    step();
    chk("sim_h4", 32'(opco_out), 32'd4);
    step();
    issue_in = 1'b0;
    chk("sim_empty", 32'(empty_out), 32'd1);

    // Branch stall and resolve
    push(16'h9010, 16'h0300);
    push(16'h1123, 16'h0302);
    issue_in = 1'b1;
    chk("br_opco", 32'(opco_out),    32'd9);
    chk("br_joff", 32'(jmp_off_out), 32'd0);
    step();
    chk("br_stall0", 32'(inst_vld_out), 32'd0);
    chk("br_opco0",  32'(opco_out),     32'd0);
    chk("br_nempty", 32'(empty_out),    32'd0);
    step();
    chk("br_stall1", 32'(inst_vld_out), 32'd0);
    step();
    chk("br_stall2", 32'(inst_vld_out), 32'd0);
    resolve_in = 1'b1;
    chk("br_k_vld", 32'(inst_vld_out), 32'd0);
    step();
    resolve_in = 1'b0;
    chk("br_k1_vld", 32'(inst_vld_out), 32'd1);
    chk("br_k1_add", {opco_out, rd_out, rs_out, rt_out}, 32'h1123);
    chk("br_k1_pc",  32'(pc_out), 32'h0302);
    step();
    issue_in = 1'b0;
    chk("br_empty", 32'(empty_out), 32'd1);

    // JAL decode, then stall with further entries queued
    push(16'hF800, 16'h0400);
    chk("jal_opco", 32'(opco_out),    32'hF);
    chk("jal_joff", 32'(jmp_off_out), 32'd2);
    chk("jal_rd",   32'(rd_out),      32'd8);
    inst_in = 16'h2456; inst_vld_in = 1'b1; issue_in = 1'b1;
    step();
    inst_vld_in = 1'b0; issue_in = 1'b0;
    chk("jal_wait_vld",   32'(inst_vld_out), 32'd0);
    chk("jal_wait_empty", 32'(empty_out),    32'd0);
    push(16'h3789, 16'h0404);
    chk("jal_wait2_vld", 32'(inst_vld_out), 32'd0);

    // Flush in WAIT with a same-cycle push, pop and resolve
    flush_in = 1'b1; inst_in = 16'h1111; inst_vld_in = 1'b1;
    issue_in = 1'b1; resolve_in = 1'b1;
    step();
    flush_in = 1'b0; inst_vld_in = 1'b0; issue_in = 1'b0; resolve_in = 1'b0;
    chk("fl_empty", 32'(empty_out),    32'd1);
    chk("fl_vld",   32'(inst_vld_out), 32'd0);
    push(16'h2222, 16'h0500);
    chk("fl_run_vld",  32'(inst_vld_out), 32'd1);
    chk("fl_run_inst", {opco_out, rd_out, rs_out, rt_out}, 32'h2222);
    issue_in = 1'b1;
    step();
    issue_in = 1'b0;
    chk("fl_drain", 32'(empty_out), 32'd1);

    // Wrap-around: one entry ahead, then 10 concurrent push/pop pairs
    push({4'd0, 4'd0, 4'd5, 4'd15}, 16'h0600);
    for (int i = 1; i <= 10; i++) begin
      inst_in     = {4'(i % 8), 4'(i), 4'd5, 4'(15 - i)};
      pc_in       = 16'h0600 + 16'(2 * i);
      inst_vld_in = 1'b1;
      issue_in    = 1'b1;
      chk("wrap_head", {opco_out, rd_out, rs_out, rt_out},
          32'({4'((i - 1) % 8), 4'(i - 1), 4'd5, 4'(16 - i)}));
      chk("wrap_pc", 32'(pc_out), 32'(16'h0600 + 16'(2 * (i - 1))));
      step();
    end
    inst_vld_in = 1'b0; issue_in = 1'b0;
    chk("wrap_last", {opco_out, rd_out, rs_out, rt_out}, 32'h2A55);
    issue_in = 1'b1;
    step();
    issue_in = 1'b0;
    chk("wrap_empty", 32'(empty_out), 32'd1);

    // Resolve while running has no visible effect
    resolve_in = 1'b1;
    push(16'h1234, 16'h0700);
    resolve_in = 1'b0;
    chk("run_resolve", 32'(inst_vld_out), 32'd1);

    // Mid-operation reset drops the queued entry
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_empty", 32'(empty_out), 32'd1);
    chk("midrst_vld",   32'(inst_vld_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_issue_queue.md
Name: inst_issue_queue

Overview:
- Producer side of the decode interface. Buffers 16-bit instruction words from instruction fetch in a small circular FIFO.
- Splits the head entry into opco/jmp_off/register fields for Control_Unit and the register file.
- Stalls issue after any control-flow instruction until the branch/jump is resolved or the pipeline is flushed.
- Sits between I-mem fetch and Control_Unit.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, >= 2
- PC_W, 16, program-counter width carried alongside each instruction

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- inst_in  in  16  fetched instruction; [15:12] opcode, [11:8] Rd, [7:4] Rs, [3:0] Rt; jmp_off = [11:10]
- pc_in  in  PC_W  PC of inst_in
- inst_vld_in  in  1  inst_in/pc_in valid this cycle
- full_out  out  1  queue holds DEPTH entries; fetch must hold its instruction
- empty_out  out  1  queue holds 0 entries
- opco_out  out  4  head opcode, to Control_Unit opco_in
- jmp_off_out  out  2  head [11:10], to Control_Unit jmp_off_in
- rd_out / rs_out / rt_out  out  4 each  head register fields
- pc_out  out  PC_W  head PC
- inst_vld_out  out  1  head entry presented for issue
- issue_in  in  1  downstream accepts head this cycle
- resolve_in  in  1  outstanding branch/jump resolved, resume issue
- flush_in  in  1  discard all entries, cancel stall

Behaviour:
- Reset (rst_n=0 at clk edge): rd/wr pointers=0, count=0, state=RUN, storage contents don't-care.
  - Outputs after reset: inst_vld_out=0, full_out=0, empty_out=1; all field outputs and pc_out = 0.
- Push: accepted iff inst_vld_in=1 and full_out=1'b0, with full evaluated at cycle start. Entry is stored at wr_ptr and wr_ptr increments modulo DEPTH. No bypass: an entry pushed in cycle N is first visible at the head in cycle N+1.
- Present: inst_vld_out = (count!=0) & (state==RUN). Field outputs come combinationally from the head entry when inst_vld_out=1; otherwise they are forced to 0, so NOP opcode 0000 reaches Control_Unit.
- Pop: occurs when inst_vld_out & issue_in. rd_ptr increments modulo DEPTH.
  - A pop with issue_in=1 while inst_vld_out=0 is ignored.
- Simultaneous push and pop: count unchanged.
  - At full: the push is rejected and the pop proceeds, so count becomes DEPTH-1.
  - At empty: nothing pops, the push succeeds, count becomes 1.
- FSM, two states:
  - RUN: a pop of a control-flow opcode (1001 BEQZ, 1010 BLTZ, 1011 BGTZ, 1111 J/JR/JAL, any jmp_off) moves to WAIT at the next edge. The popped instruction itself issues normally.
  - WAIT: inst_vld_out=0. Pushes are still accepted until full. resolve_in=1 returns to RUN at the next edge, and the head is presentable that next cycle.
  - resolve_in in RUN is ignored.
- flush_in=1, highest priority after reset:
  - Next edge: count=0, pointers=0, state=RUN.
  - A same-cycle push is dropped and a same-cycle pop has no effect.
  - resolve_in is ignored.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. count is clog2(DEPTH)+1 bits, range 0..DEPTH.
- Status flags: full_out = (count==DEPTH) and empty_out = (count==0). Both are derived from the registered count.
- Reset mid-operation: identical to power-on reset. In-flight entries and any stall are lost.

Decomposition:
- Shared package (isa_pkg):
  - opcode localparams OP_NOP..OP_JMP (0000..1111)
  - instruction field bit positions
  - function is_ctrl_flow(opcode), returning 1 for 1001/1010/1011/1111
  - Control_Unit is to adopt the same constants
- One sub-module: inst_queue_mem, the DEPTH x (16+PC_W) register array with registered write port and combinational read port.
  - The FSM, pointers and count stay in the top.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with inst_vld_in=1.
  - Required: inst_vld_out=0, empty_out=1, full_out=0, opco_out=0, and nothing is enqueued.
- Fill and backpressure:
  - Stimulus: push 0x1123, 0x2456, 0x3789, 0x4ABC with issue_in=0, then a 5th push of 0x5DEF.
  - Required: full_out=1 after the 4th push and the 5th push is rejected.
  - Then issue_in=1 for 4 cycles pops opco 1,2,3,4 in order with rd/rs/rt matching, and empty_out=1 afterwards.
- Simultaneous push/pop at full:
  - Stimulus: queue full, issue_in=1 and inst_vld_in=1 in the same cycle.
  - Required: count=3, full_out=0, and the pushed word is not stored.
- Branch stall:
  - Stimulus: queue holds 0x9010 (BEQZ), 0x1123; issue_in=1.
  - Required: BEQZ issues, then inst_vld_out=0 for as long as resolve_in=0.
  - resolve_in=1 in cycle k makes ADD 0x1123 presented in cycle k+1.
- JAL decode:
  - Stimulus: push 0xF800.
  - Required: opco_out=1111, jmp_off_out=10 while presented; after the pop, state=WAIT.
- Flush during WAIT with a same-cycle push:
  - Stimulus: WAIT with 2 entries queued, flush_in=1 and inst_vld_in=1 (0x1111).
  - Required next cycle: empty_out=1, inst_vld_out=0, state RUN.
  - Then a push of 0x2222 is presented the following cycle.
  - Wrap-around: 10 push/pop pairs with DEPTH=4 preserve order.
